// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with busy scoreboard and sequenced soft clear.
// Latency: reads are combinational (0 cycles); writes, issues and clears take effect at the next rising edge.
// Backpressure: none. we / iss_valid / clr_req are dropped while a clear is in progress (clr_busy or clr_done high).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ra_a/ra_b -> rd_a/rd_b, busy_a/busy_b
//                        read ports with per-register pending-writer flags
//   we, wa, wd           writeback port; it also clears the busy flag of wa
//   iss_valid, iss_addr  issue port; it marks iss_addr as having a pending writer
//   clr_req              starts a soft clear of R1..R(DEPTH-1)
//   clr_busy, clr_done   clear in progress / one-cycle completion pulse
// Register 0 is never written, so it reads 0 and is never busy.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_a,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic [DATA_W-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]   busy;

    logic idle;
    logic wr_en;
    logic iss_en;

    // Writes and issues are only accepted in IDLE; address 0 is filtered here
    // so R0 and busy[0] keep their reset value of zero forever.
    assign idle   = (state == IDLE);
    assign wr_en  = we && (wa != '0) && idle;
    assign iss_en = iss_valid && (iss_addr != '0) && idle;

    // Clear sequencer. clr_busy / clr_done are registered alongside the state
    // so they are glitch-free and drop immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= CLEAR;
                        idx      <= IDX_ONE;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx == IDX_LAST) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Register array: one entry cleared per CLEAR cycle, else normal writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[idx] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Scoreboard. The issue assignment comes after the writeback clear so a
    // same-address issue+write in one cycle leaves the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (state == CLEAR) begin
            busy[idx] <= 1'b0;
        end else begin
            if (wr_en) begin
                busy[wa] <= 1'b0;
            end
            if (iss_en) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    // Read ports. With bypass, a matching write in flight is forwarded and the
    // register is reported not busy, since its writer is completing right now.
    always_comb begin
        rd_a   = regs[ra_a];
        rd_b   = regs[ra_b];
        busy_a = busy[ra_a];
        busy_b = busy[ra_b];
        if ((BYPASS != 0) && wr_en) begin
            if (wa == ra_a) begin
                rd_a   = wd;
                busy_a = 1'b0;
            end
            if (wa == ra_b) begin
                rd_b   = wd;
                busy_b = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra_a, ra_b, wa, iss_addr;
    logic [31:0] wd;
    logic        we, iss_valid, clr_req;

    // DUT with bypass
    logic [31:0] rd_a1, rd_b1;
    logic        busy_a1, busy_b1, clr_busy1, clr_done1;
    // DUT without bypass
    logic [31:0] rd_a0, rd_b0;
    logic        busy_a0, busy_b0, clr_busy0, clr_done0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .ra_a(ra_a), .ra_b(ra_b),
        .rd_a(rd_a1), .rd_b(rd_b1), .busy_a(busy_a1), .busy_b(busy_b1),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .clr_req(clr_req), .clr_busy(clr_busy1), .clr_done(clr_done1)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .ra_a(ra_a), .ra_b(ra_b),
        .rd_a(rd_a0), .rd_b(rd_b0), .busy_a(busy_a0), .busy_b(busy_b0),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .clr_req(clr_req), .clr_busy(clr_busy0), .clr_done(clr_done0)
    );

    // ---------------- behavioural model ----------------
    // m_left: clear cycles still to run (the register cleared this cycle is DEPTH-m_left)
    // m_done: the completion pulse cycle
    logic [31:0] m_r [DEPTH];
    logic        m_b [DEPTH];
    int          m_left;
    logic        m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_r[i] = 32'd0;
                m_b[i] = 1'b0;
            end
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_r[DEPTH - m_left] = 32'd0;
            m_b[DEPTH - m_left] = 1'b0;
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
        end else begin
            if (we && wa != 5'd0) begin
                m_r[wa] = wd;
                m_b[wa] = 1'b0;
            end
            if (iss_valid && iss_addr != 5'd0) m_b[iss_addr] = 1'b1;
            if (clr_req) m_left = DEPTH - 1;
        end
    end

    function automatic logic fwd(input logic [4:0] addr, input bit byp);
        return byp && we && (wa != 5'd0) && (wa == addr) && (m_left == 0) && !m_done;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] addr, input bit byp);
        return fwd(addr, byp) ? wd : m_r[addr];
    endfunction

    function automatic logic exp_busy(input logic [4:0] addr, input bit byp);
        return fwd(addr, byp) ? 1'b0 : m_b[addr];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Sample at the falling edge and compare every output of both DUTs with the model.
    task automatic cmp();
        @(negedge clk);
        chk("rd_a_byp",     rd_a1,     exp_rd(ra_a, 1'b1));
        chk("rd_b_byp",     rd_b1,     exp_rd(ra_b, 1'b1));
        chk("busy_a_byp",   {31'd0, busy_a1}, {31'd0, exp_busy(ra_a, 1'b1)});
        chk("busy_b_byp",   {31'd0, busy_b1}, {31'd0, exp_busy(ra_b, 1'b1)});
        chk("rd_a_nobyp",   rd_a0,     exp_rd(ra_a, 1'b0));
        chk("rd_b_nobyp",   rd_b0,     exp_rd(ra_b, 1'b0));
        chk("busy_a_nobyp", {31'd0, busy_a0}, {31'd0, exp_busy(ra_a, 1'b0)});
        chk("busy_b_nobyp", {31'd0, busy_b0}, {31'd0, exp_busy(ra_b, 1'b0)});
        chk("clr_busy_byp",   {31'd0, clr_busy1}, {31'd0, (m_left > 0)});
        chk("clr_done_byp",   {31'd0, clr_done1}, {31'd0, m_done});
        chk("clr_busy_nobyp", {31'd0, clr_busy0}, {31'd0, (m_left > 0)});
        chk("clr_done_nobyp", {31'd0, clr_done0}, {31'd0, m_done});
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        cmp();
        adv();
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = 5'd0; wd = 32'd0;
        iss_valid = 1'b0; iss_addr = 5'd0; clr_req = 1'b0;
    endtask

    task automatic fill_regs();
        for (int i = 1; i < DEPTH; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'h1000_0000 | 32'(i);
            cycle();
        end
        we = 1'b0;
    endtask

    int busy_cnt, done_cnt;

    initial begin
        rst_n = 1'b0;
        ra_a = 5'd0; ra_b = 5'd0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state: all addresses read 0 and not busy
        for (int a = 0; a < DEPTH; a++) begin
            ra_a = 5'(a); ra_b = 5'(DEPTH - 1 - a);
            cmp();
            chk("reset_rd_a", rd_a1, 32'd0);
            chk("reset_rd_b", rd_b0, 32'd0);
            chk("reset_busy_a", {31'd0, busy_a1}, 32'd0);
            adv();
        end
        chk("reset_clr_busy", {31'd0, clr_busy1}, 32'd0);

        // Same-cycle bypass vs no bypass
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra_a = 5'd5;
        cmp();
        chk("bypass_same_cycle", rd_a1, 32'hDEAD_BEEF);
        chk("nobypass_same_cycle", rd_a0, 32'd0);
        adv();
        we = 1'b0;
        cmp();
        chk("bypass_next_cycle", rd_a1, 32'hDEAD_BEEF);
        chk("nobypass_next_cycle", rd_a0, 32'hDEAD_BEEF);
        adv();

        // Register 0 is hardwired
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra_a = 5'd0;
        cycle();
        we = 1'b0; iss_valid = 1'b1; iss_addr = 5'd0;
        cmp();
        chk("r0_reads_zero", rd_a1, 32'd0);
        adv();
        iss_valid = 1'b0;
        cmp();
        chk("r0_never_busy", {31'd0, busy_a1}, 32'd0);
        adv();

        // Scoreboard: issue sets, write clears, issue+write -> busy with data
        iss_valid = 1'b1; iss_addr = 5'd7; ra_a = 5'd7;
        cycle();
        iss_valid = 1'b0;
        cmp();
        chk("issue_sets_busy", {31'd0, busy_a0}, 32'd1);
        adv();
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0777;
        cycle();
        we = 1'b0;
        cmp();
        chk("write_clears_busy", {31'd0, busy_a1}, 32'd0);
        adv();
        we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; iss_valid = 1'b1; iss_addr = 5'd7;
        cycle();
        we = 1'b0; iss_valid = 1'b0;
        cmp();
        chk("issue_wins_busy", {31'd0, busy_a1}, 32'd1);
        chk("issue_write_data", rd_a0, 32'h1234_5678);
        adv();

        // Full soft clear with an injected write/issue/re-request mid-clear
        fill_regs();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        ra_a = 5'd3; ra_b = 5'd4;
        for (int i = 0; i < 40; i++) begin
            cmp();
            if (clr_busy1) busy_cnt++;
            if (clr_done1) done_cnt++;
            we = (i == 10); wa = 5'd3; wd = 32'hBAD0_0003;
            iss_valid = (i == 10); iss_addr = 5'd4;
            clr_req = (i == 12);
            adv();
        end
        idle_inputs();
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd31);
        chk("clear_done_pulses", 32'(done_cnt), 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            ra_a = 5'(a);
            cmp();
            chk("cleared_rd", rd_a1, 32'd0);
            chk("cleared_busy", {31'd0, busy_a0}, 32'd0);
            adv();
        end

        // Reset in the middle of a clear
        fill_regs();
        ra_a = 5'd20;
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rst_n = 1'b0;
        #1;
        chk("abort_clr_busy", {31'd0, clr_busy1}, 32'd0);
        chk("abort_clr_done", {31'd0, clr_done0}, 32'd0);
        chk("abort_rd_r20", rd_a1, 32'd0);
        cycle();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cmp();
            if (clr_done1 || clr_done0) done_cnt++;
            adv();
        end
        chk("abort_no_done_pulse", 32'(done_cnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            we        = 1'($urandom_range(0, 1));
            wa        = 5'($urandom_range(0, DEPTH - 1));
            wd        = $urandom;
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_addr  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, DEPTH - 1));
            clr_req   = ($urandom_range(0, 99) == 0);
            ra_a      = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, DEPTH - 1));
            ra_b      = ($urandom_range(0, 2) == 0) ? iss_addr : 5'($urandom_range(0, DEPTH - 1));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
